// File: rtl/synth_pkg.sv
// synth_pkg: shared constants and types for the MIDI voice allocator.
//   NOTE_ON / NOTE_OFF   : MIDI status nibbles for channel voice messages
//   NOTE_COUNT           : number of playable notes (piano range)
//   DEFAULT_NUM_VOICES   : default polyphony
//   parse_state_t        : byte parser states
package synth_pkg;

  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;

  localparam int NOTE_COUNT         = 88;
  localparam int DEFAULT_NUM_VOICES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2,
    ALLOC = 2'd3
  } parse_state_t;

endpackage

// File: rtl/voice_lru.sv
// voice_lru: least-recently-used ranking of the voice table.
//   clk, nreset : clock, asynchronous active-low reset (age[i] = i)
//   touch       : mark voice touch_idx as most recent this cycle
//   touch_idx   : voice being touched
//   oldest      : index of the voice whose age is N-1
// Ages always form a permutation of 0..N-1.
module voice_lru #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 touch,
  input  logic [$clog2(N)-1:0] touch_idx,
  output logic [$clog2(N)-1:0] oldest
);

  localparam int AW = $clog2(N);

  logic [AW-1:0] age [N];
  logic [AW-1:0] touched_age;

  assign touched_age = age[touch_idx];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < N; i++) age[i] <= AW'(i);
    end else if (touch) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (AW'(i) == touch_idx)      age[i] <= '0;
        else if (age[i] < touched_age) age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    oldest = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (age[i] == AW'(N - 1)) oldest = AW'(i);
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: MIDI note-on/note-off parser with polyphonic voice table.
//   clk, nreset   : clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_ready : byte stream in (accepted when valid && ready)
//   voice_note    : packed 7-bit note table index per voice (note - NOTE_LO)
//   voice_gate    : voice held
//   voice_vel     : packed 7-bit velocity per voice
//   voice_retrig  : one-cycle pulse when a voice starts/restarts a note
//   overflow      : one-cycle pulse when a note-on is dropped
// Build option: define VOICE_STEAL_EN to overwrite the oldest voice when all
// voices are held; otherwise the note-on is dropped and overflow pulses.
module midi_voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_VOICES   = DEFAULT_NUM_VOICES,
  parameter int MIDI_CHANNEL = 0,
  parameter int NOTE_LO      = 21
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_retrig,
  output logic                    overflow
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [7:0] LO8 = 8'(NOTE_LO);
  localparam logic [7:0] HI8 = 8'(NOTE_LO + NOTE_COUNT - 1);

  parse_state_t state, state_nx;

  logic       rs_valid, rs_on;
  logic [6:0] note_q, vel_q;

  logic       accept, is_rt, is_status, is_voice_msg;

  logic [6:0] note_arr [NUM_VOICES];
  logic [6:0] vel_arr  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_r, retrig_r, match;
  logic       ovf_r, ovf_nx;

  logic       note_ok, is_on, hit, free_any, do_on, do_off;
  logic [6:0] idx;
  logic [IW-1:0] hit_idx, free_idx, sel, oldest;

  // ---------------------------------------------------------------- parser
  assign rx_ready     = (state != ALLOC);
  assign accept       = rx_valid && rx_ready;
  assign is_rt        = (rx_data >= 8'hF8);
  assign is_status    = rx_data[7];
  assign is_voice_msg = ((rx_data[7:4] == NOTE_ON) || (rx_data[7:4] == NOTE_OFF)) &&
                        (rx_data[3:0] == 4'(MIDI_CHANNEL));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  // A status byte is handled the same way in IDLE, DATA1 and DATA2, which
  // abandons any partial message.
  always_comb begin
    state_nx = state;
    if (state == ALLOC) begin
      state_nx = IDLE;
    end else if (accept && !is_rt) begin
      if (is_status) begin
        state_nx = is_voice_msg ? DATA1 : IDLE;
      end else begin
        case (state)
          IDLE:    if (rs_valid) state_nx = DATA2;
          DATA1:   state_nx = DATA2;
          DATA2:   state_nx = ALLOC;
          default: state_nx = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rs_valid <= 1'b0;
      rs_on    <= 1'b0;
      note_q   <= '0;
      vel_q    <= '0;
    end else if (accept && !is_rt) begin
      if (is_status) begin
        rs_valid <= is_voice_msg;
        rs_on    <= (rx_data[7:4] == NOTE_ON);
      end else if (state == DATA2) begin
        vel_q <= rx_data[6:0];
      end else if (state == DATA1 || (state == IDLE && rs_valid)) begin
        note_q <= rx_data[6:0];
      end
    end
  end

  // ------------------------------------------------------------ allocation
  assign note_ok = ({1'b0, note_q} >= LO8) && ({1'b0, note_q} <= HI8);
  assign idx     = note_q - 7'(NOTE_LO);
  assign is_on   = rs_on && (vel_q != 7'd0);

  always_comb begin
    match    = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      match[i] = gate_r[i] && (note_arr[i] == idx);
      if (match[i] && !hit) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!gate_r[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    do_on  = 1'b0;
    do_off = 1'b0;
    sel    = '0;
    ovf_nx = 1'b0;
    if (state == ALLOC && note_ok) begin
      if (is_on) begin
        if (hit) begin
          sel   = hit_idx;
          do_on = 1'b1;
        end else if (free_any) begin
          sel   = free_idx;
          do_on = 1'b1;
        end else begin
`ifdef VOICE_STEAL_EN
          sel   = oldest;
          do_on = 1'b1;
`else
          ovf_nx = 1'b1;
`endif
        end
      end else begin
        do_off = 1'b1;
      end
    end
  end

`ifndef VOICE_STEAL_EN
  logic lru_unused;
  assign lru_unused = ^oldest;
`endif

  voice_lru #(.N(NUM_VOICES)) u_lru (
    .clk       (clk),
    .nreset    (nreset),
    .touch     (do_on),
    .touch_idx (sel),
    .oldest    (oldest)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_arr[i] <= '0;
        vel_arr[i]  <= '0;
      end
      gate_r   <= '0;
      retrig_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      retrig_r <= '0;
      ovf_r    <= ovf_nx;
      if (do_on) begin
        note_arr[sel] <= idx;
        vel_arr[sel]  <= vel_q;
        gate_r[sel]   <= 1'b1;
        retrig_r[sel] <= 1'b1;
      end
      // Note and velocity are kept on note-off so the release tail can run.
      if (do_off) gate_r <= gate_r & ~match;
    end
  end

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_note[i*7 +: 7] = note_arr[i];
      voice_vel[i*7 +: 7]  = vel_arr[i];
    end
  end

  assign voice_gate   = gate_r;
  assign voice_retrig = retrig_r;
  assign overflow     = ovf_r;

endmodule

// File: tb/tb_midi_voice_alloc.sv
module tb_midi_voice_alloc;

  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          nreset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic [7*NV-1:0] voice_note, voice_vel;
  logic [NV-1:0] voice_gate, voice_retrig;
  logic          overflow;

  midi_voice_alloc #(.NUM_VOICES(NV), .MIDI_CHANNEL(0), .NOTE_LO(21)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .voice_note   (voice_note),
    .voice_gate   (voice_gate),
    .voice_vel    (voice_vel),
    .voice_retrig (voice_retrig),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string           tag;
    logic [7*NV-1:0] note;
    logic [7*NV-1:0] vel;
    logic [NV-1:0]   gate;
    logic [NV-1:0]   retrig;
    logic            ovf;
  } exp_t;

  exp_t sb[$];

  // Reference table
  logic [7*NV-1:0] m_note, m_vel;
  logic [NV-1:0]   m_gate;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_voice(input int v, input logic [6:0] n, input logic [6:0] vl, input logic g);
    m_note[v*7 +: 7] = n;
    m_vel[v*7 +: 7]  = vl;
    m_gate[v]        = g;
  endtask

  task automatic push_exp(input string tag, input logic [NV-1:0] rt, input logic ov);
    exp_t e;
    e.tag    = tag;
    e.note   = m_note;
    e.vel    = m_vel;
    e.gate   = m_gate;
    e.retrig = rt;
    e.ovf    = ov;
    sb.push_back(e);
  endtask

  // Drive one byte; returns 1ns after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("ready_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Call right after the velocity byte was accepted.
  task automatic alloc_check();
    exp_t e;
    chk("rx_ready_in_alloc", 64'(rx_ready), 64'd0);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_note"},   64'(voice_note),   64'(e.note));
      chk({e.tag, "_vel"},    64'(voice_vel),    64'(e.vel));
      chk({e.tag, "_gate"},   64'(voice_gate),   64'(e.gate));
      chk({e.tag, "_retrig"}, 64'(voice_retrig), 64'(e.retrig));
      chk({e.tag, "_ovf"},    64'(overflow),     64'(e.ovf));
      chk({e.tag, "_ready"},  64'(rx_ready),     64'd1);
    end
    @(posedge clk);
    #1;
    chk("retrig_one_cycle", 64'(voice_retrig), 64'd0);
    chk("ovf_one_cycle",    64'(overflow),     64'd0);
  endtask

  task automatic check_table(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_note"},   64'(voice_note),   64'(m_note));
    chk({tag, "_vel"},    64'(voice_vel),    64'(m_vel));
    chk({tag, "_gate"},   64'(voice_gate),   64'(m_gate));
    chk({tag, "_retrig"}, 64'(voice_retrig), 64'd0);
    chk({tag, "_ovf"},    64'(overflow),     64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    m_note = '0;
    m_vel  = '0;
    m_gate = '0;
    chk({tag, "_note"},   64'(voice_note),   64'd0);
    chk({tag, "_vel"},    64'(voice_vel),    64'd0);
    chk({tag, "_gate"},   64'(voice_gate),   64'd0);
    chk({tag, "_retrig"}, 64'(voice_retrig), 64'd0);
    chk({tag, "_ovf"},    64'(overflow),     64'd0);
    chk({tag, "_ready"},  64'(rx_ready),     64'd1);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    m_note = '0;
    m_vel  = '0;
    m_gate = '0;
    #2;
    do_reset("reset");

    // Plain note-on: note 60 -> index 39, velocity 100, voice 0
    set_voice(0, 7'd39, 7'd100, 1'b1);
    push_exp("non_basic", 8'h01, 1'b0);
    send(8'h90); send(8'h3C); send(8'h64);
    alloc_check();

    // Running status: note 64 -> index 43, velocity 80, voice 1
    set_voice(1, 7'd43, 7'd80, 1'b1);
    push_exp("non_running", 8'h02, 1'b0);
    send(8'h40); send(8'h50);
    alloc_check();

    // Velocity-0 note-on releases voice 0, note kept
    set_voice(0, 7'd39, 7'd100, 1'b0);
    push_exp("noff_vel0", 8'h00, 1'b0);
    send(8'h3C); send(8'h00);
    alloc_check();

    // Real-time byte inside a message is transparent; voice 0 is free again
    set_voice(0, 7'd39, 7'd100, 1'b1);
    push_exp("non_realtime", 8'h01, 1'b0);
    send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);
    alloc_check();

    // Control-change status aborts and clears running status
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h40); send(8'h64);
    check_table("cc_abort");

    // Note below range: discarded in ALLOC without overflow
    push_exp("note_low", 8'h00, 1'b0);
    send(8'h90); send(8'h14); send(8'h64);
    alloc_check();

    // Other channel: ignored entirely
    send(8'h91); send(8'h3C); send(8'h64);
    check_table("other_chan");

    // Repeated note-on on held note reuses voice 0 with new velocity
    set_voice(0, 7'd39, 7'd32, 1'b1);
    push_exp("non_repeat", 8'h01, 1'b0);
    send(8'h90); send(8'h3C); send(8'h20);
    alloc_check();

    // Fill all voices, then one more note-on
    do_reset("reset2");
    send(8'h90);
    for (int i = 0; i < NV; i++) begin
      set_voice(i, 7'(39 + i), 7'd64, 1'b1);
      push_exp("fill", 8'(1 << i), 1'b0);
      send(8'(8'h3C + i)); send(8'h40);
      alloc_check();
    end
`ifdef VOICE_STEAL_EN
    set_voice(0, 7'd59, 7'd127, 1'b1);
    push_exp("ninth_steal", 8'h01, 1'b0);
`else
    push_exp("ninth_drop", 8'h00, 1'b1);
`endif
    send(8'h50); send(8'h7F);
    alloc_check();

    // Reset between note and velocity: partial message lost
    send(8'h90); send(8'h3C);
    do_reset("reset_mid");
    send(8'h64);
    check_table("after_mid_reset");
    chk("after_mid_reset_ready", 64'(rx_ready), 64'd1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
